imem_sync: RTL
==============

# imem_sync

Parametrised, clocked instruction memory for the processor fetch stage. Replaces the fixed combinational ROM with a writable word array, one-cycle registered read, a request/valid handshake, and alignment/range checks. After reset it clears itself by sweeping every word to zero, then accepts fetches from the PC and program writes from the loader port.

## Interface

**Parameters**
- `DATA_W`, 32: instruction word width in bits.
- `ADDR_W`, 32: byte-address width.
- `DEPTH`, 64: number of words. Must be a power of two and at least 2.

**Ports**
- `CLK`, input, 1: single clock. All logic is rising-edge.
- `RST_N`, input, 1: asynchronous, active-low reset.
- `REQ`, input, 1: fetch request.
- `ADDR`, input, `ADDR_W`: fetch byte address.
- `RDY`, output, 1: the block can accept a fetch or a write this cycle.
- `VALID`, output, 1: one-cycle pulse meaning `RD` and `FAULT` hold the result of the accepted fetch.
- `RD`, output, `DATA_W`: fetched instruction, registered.
- `FAULT`, output, 1: the accepted fetch was misaligned. Qualified by `VALID`.
- `WE`, input, 1: program write strobe.
- `WADDR`, input, `ADDR_W`: write byte address.
- `WD`, input, `DATA_W`: write data.

## Operation

**State machine.** States are `INIT` and `RUN`.
- Reset enters `INIT` with the sweep counter at 0.
- `INIT` writes 0 to word[counter] every cycle and increments the counter.
- When counter = `DEPTH`-1 has been written, the next state is `RUN`.
- `RUN` is terminal until the next reset.

**Ready.** `RDY` = 1 only in `RUN`. `REQ` and `WE` are ignored while `RDY` = 0; nothing queues.

**Fetch accepted** when `REQ` && `RDY`:
- Word index = `ADDR[log2(DEPTH)+1:2]`.
- If `ADDR[1:0]` != 0: `RD` = 0, `FAULT` = 1.
- Else if `ADDR >> 2` >= `DEPTH` (out of range): `RD` = 0, `FAULT` = 0.
- Else: `RD` = word[index], `FAULT` = 0.
- A fetch can be accepted every cycle, so back-to-back fetches give back-to-back `VALID`.

**Write accepted** when `WE` && `RDY`:
- Writes `WD` to word[index] only if `WADDR` is aligned and in range.
- Otherwise the write is silently dropped.

**Simultaneous events.**
- Fetch and write to the same word in one cycle: the fetch returns the old contents (read-before-write). The write lands.
- Fetch and write to different words proceed independently.

**Output holding.** `RD` and `FAULT` hold their last values until the next accepted fetch.

**Reset values.** `RDY` = 0, `VALID` = 0, `RD` = 0, `FAULT` = 0, state = `INIT`, counter = 0.

**Reset mid-operation.** Asserting `RST_N` low forces all outputs to their reset values immediately (asynchronous). The sweep restarts from 0. Any fetch in flight is lost and `VALID` is not produced for it.

## Timing

- Fetch latency is 1: request accepted at edge N gives `VALID`/`RD`/`FAULT` after edge N+1.
- Write latency is 1: a write at edge N is visible to a fetch accepted at edge N+1.
- `INIT` lasts exactly `DEPTH` cycles. `RDY` rises on the cycle after the last clear write. With the default, the first `RUN` cycle is cycle 64 after reset release.
- `RST_N` deassertion is synchronised externally. The block samples its first edge after release as `INIT` cycle 0.
- No combinational path from any input to any output.

## Structure

**Package `imem_pkg`:**
- State enum {`INIT`, `RUN`}.
- `WORD_BYTES` = 4 and the byte-offset width constant 2.
- `IDX_W` = clog2(`DEPTH`) function or macro.

**Sub-module `imem_ram`:**
- `DEPTH` x `DATA_W` array with one synchronous write port and one synchronous read-before-write port.
- The top multiplexes the sweep and loader writes onto its single write port.
- The top holds the FSM, checks, handshake and output registers.

## Test plan

1. Release reset:
   - `RDY` = 0 for exactly 64 cycles, then 1.
   - `VALID` is never 1 during `INIT`.
   - A fetch of `ADDR` 0x3C after `INIT` returns `RD` = 0.
2. Write 0x020081E0 at `WADDR` 0 and 0x021044E0 at `WADDR` 4, then fetch 0 and 4 back-to-back:
   - `VALID` is high on two consecutive cycles.
   - `RD` = 0x020081E0, then 0x021044E0.
3. Misaligned and out-of-range fetches:
   - Fetch `ADDR` 6 gives `VALID` = 1, `FAULT` = 1, `RD` = 0.
   - Fetch `ADDR` 0x100 (word 64, out of range) gives `VALID` = 1, `FAULT` = 0, `RD` = 0.
   - Write to `WADDR` 0x102 leaves all words unchanged.
4. Same-word collision:
   - With word 2 = 0x014003E0, write 0xDEADBEEF at `WADDR` 8 and fetch `ADDR` 8 in the same cycle: `RD` = 0x014003E0.
   - Fetch `ADDR` 8 on the next cycle: `RD` = 0xDEADBEEF.
5. Reset during `RUN` with a fetch in flight:
   - `VALID`, `RD` and `RDY` go to 0 asynchronously, with no `VALID` pulse afterward.
   - `INIT` takes 64 cycles again, after which previously written words read 0.
6. Reset at `INIT` cycle 30:
   - The sweep restarts.
   - `RDY` rises 64 cycles after the second release, not 34.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the clocked instruction memory.
package imem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int OFFS_W     = 2;

  // Width of a word index for a memory of the given depth (at least one bit).
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_sync_if.sv
// Fetch and loader-write handshake bundle between the fetch stage and the memory.
interface imem_sync_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              rdy;
  logic              valid;
  logic [DATA_W-1:0] rd;
  logic              fault;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wd;

  modport master (
    output req, addr, we, waddr, wd,
    input  rdy, valid, rd, fault
  );

  modport slave (
    input  req, addr, we, waddr, wd,
    output rdy, valid, rd, fault
  );

endinterface

// File: rtl/imem_ram.sv
// Word array with one synchronous write port and one registered
// read-before-write port; the read register holds until the next read.
module imem_ram
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Storage write; the array itself is not reset, the sweep clears it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Next read data: capture the pre-write contents on a read, else hold.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[ridx];
    end
  end

  // Read data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_sync.sv
// Clocked instruction memory: clears itself after reset, then serves
// fetches with a one-cycle registered result and accepts loader writes.
// DEPTH must be a power of two and at least 2.
module imem_sync
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64
) (
  input logic         clk,
  input logic         rst_n,
  imem_sync_if.slave  bus
);

  localparam int               IDX_W    = idx_w(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic              zero_q, zero_d;

  logic              rdy;
  logic              fetch_acc, fetch_mis, fetch_oor, fetch_ok;
  logic [IDX_W-1:0]  fetch_idx;
  logic              wr_mis, wr_oor, wr_ok;
  logic [IDX_W-1:0]  wr_idx;

  logic              ram_we;
  logic [IDX_W-1:0]  ram_widx;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign rdy = (state_q == RUN);

  // Alignment and range classification of the fetch and write addresses.
  always_comb begin
    fetch_acc = bus.req && rdy;
    fetch_mis = (bus.addr[OFFS_W-1:0] != '0);
    fetch_oor = ((bus.addr >> (IDX_W + OFFS_W)) != '0);
    fetch_ok  = fetch_acc && !fetch_mis && !fetch_oor;
    fetch_idx = bus.addr[IDX_W+OFFS_W-1:OFFS_W];
    wr_mis    = (bus.waddr[OFFS_W-1:0] != '0);
    wr_oor    = ((bus.waddr >> (IDX_W + OFFS_W)) != '0);
    wr_ok     = bus.we && rdy && !wr_mis && !wr_oor;
    wr_idx    = bus.waddr[IDX_W+OFFS_W-1:OFFS_W];
  end

  // Next state, sweep counter, write-port mux and fetch result flags.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    fault_d   = fault_q;
    zero_d    = zero_q;
    ram_we    = 1'b0;
    ram_widx  = wr_idx;
    ram_wdata = bus.wd;
    case (state_q)
      INIT: begin
        ram_we    = 1'b1;
        ram_widx  = cnt_q;
        ram_wdata = '0;
        cnt_d     = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        ram_we = wr_ok;
        if (fetch_acc) begin
          valid_d = 1'b1;
          fault_d = fetch_mis;
          zero_d  = !fetch_ok;
        end
      end
    endcase
  end

  // State, counter and output-qualifier registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      zero_q  <= zero_d;
    end
  end

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .widx  (ram_widx),
    .wdata (ram_wdata),
    .re    (fetch_ok),
    .ridx  (fetch_idx),
    .rdata (ram_rdata)
  );

  assign bus.rdy   = rdy;
  assign bus.valid = valid_q;
  assign bus.fault = fault_q;
  assign bus.rd    = zero_q ? '0 : ram_rdata;

endmodule
